// File: rtl/mastermind_pkg.sv
// Shared types and constants for the Mastermind game engine.
// Holds the FSM state encoding, default sizing and the LFSR next-state helper.
package mastermind_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_SCORE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int          DEF_NUM_PEGS   = 4;
    localparam int          DEF_COLOR_BITS = 2;
    localparam int          DEF_MAX_TURNS  = 8;
    localparam logic [15:0] DEF_SEED       = 16'hACE1;

    // Taps 16,14,13,11 (1-based), i.e. bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mastermind_game_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used as the random secret-code source.
module random_lfsr
    import mastermind_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_SEED
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] value
);

    // Advance on every cycle outside reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            value <= SEED;
        end else begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/mastermind_game.sv
// Mastermind game engine: holds a secret code, scores guesses one color per
// cycle and tracks turns until the player wins or runs out of guesses.
module mastermind_game
    import mastermind_pkg::*;
#(
    parameter int          NUM_PEGS   = DEF_NUM_PEGS,
    parameter int          COLOR_BITS = DEF_COLOR_BITS,
    parameter int          MAX_TURNS  = DEF_MAX_TURNS,
    parameter logic [15:0] SEED       = DEF_SEED
) (
    input  logic                               Clock,
    input  logic                               Reset,
    input  logic                               new_game,
    input  logic                               load_code,
    input  logic [NUM_PEGS*COLOR_BITS-1:0]     code_in,
    input  logic                               guess_valid,
    input  logic [NUM_PEGS*COLOR_BITS-1:0]     guess,
    output logic                               busy,
    output logic                               score_valid,
    output logic [$clog2(NUM_PEGS+1)-1:0]      exact,
    output logic [$clog2(NUM_PEGS+1)-1:0]      misplaced,
    output logic [$clog2(MAX_TURNS+1)-1:0]     turn_count,
    output logic                               win,
    output logic                               lose,
    output logic [NUM_PEGS*COLOR_BITS-1:0]     code_out
);

    localparam int CODE_W     = NUM_PEGS * COLOR_BITS;
    localparam int NUM_COLORS = 2 ** COLOR_BITS;
    localparam int CNT_W      = $clog2(NUM_PEGS + 1);
    localparam int TURN_W     = $clog2(MAX_TURNS + 1);

    if (CODE_W > 16) begin : g_code_w_check
        $error("mastermind_game: NUM_PEGS*COLOR_BITS must not exceed 16");
    end
    if (SEED == 16'h0000) begin : g_seed_check
        $error("mastermind_game: SEED must be nonzero");
    end

    state_e              state_r, state_nxt_s;
    logic [15:0]         lfsr_s;
    logic                lfsr_unused_s;
    logic [CODE_W-1:0]   secret_r, guess_r;
    logic [CNT_W-1:0]    exact_pend_r, hits_r, hits_nxt_s, guess_exact_s;
    logic [COLOR_BITS-1:0] color_r;
    logic                last_color_s;
    logic [CNT_W-1:0]    exact_r, misplaced_r;
    logic [TURN_W-1:0]   turn_r;
    logic                win_r, lose_r, score_valid_r;

    random_lfsr #(.SEED(SEED)) u_lfsr (
        .Clock (Clock),
        .Reset (Reset),
        .value (lfsr_s)
    );

    // Only the low CODE_W bits feed the code; the rest are intentionally dropped.
    assign lfsr_unused_s = ^lfsr_s;

    function automatic logic [CNT_W-1:0] count_color(input logic [CODE_W-1:0] c,
                                                      input logic [COLOR_BITS-1:0] col);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (c[i*COLOR_BITS +: COLOR_BITS] == col) n = n + CNT_W'(1);
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] count_exact(input logic [CODE_W-1:0] a,
                                                      input logic [CODE_W-1:0] b);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (a[i*COLOR_BITS +: COLOR_BITS] == b[i*COLOR_BITS +: COLOR_BITS]) n = n + CNT_W'(1);
        end
        return n;
    endfunction

    // Per-color hit accumulation and exact count of an incoming guess.
    always_comb begin
        logic [CNT_W-1:0] in_code_s, in_guess_s;
        in_code_s     = count_color(secret_r, color_r);
        in_guess_s    = count_color(guess_r, color_r);
        hits_nxt_s    = hits_r + ((in_code_s < in_guess_s) ? in_code_s : in_guess_s);
        guess_exact_s = count_exact(secret_r, guess);
        last_color_s  = (color_r == COLOR_BITS'(NUM_COLORS - 1));
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; new_game overrides everything else.
    always_comb begin
        state_nxt_s = state_r;
        if (new_game) begin
            state_nxt_s = ST_PLAY;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_IDLE;
                ST_PLAY:  state_nxt_s = guess_valid ? ST_SCORE : ST_PLAY;
                ST_SCORE: begin
                    if (!last_color_s) begin
                        state_nxt_s = ST_SCORE;
                    end else if (exact_pend_r == CNT_W'(NUM_PEGS)) begin
                        state_nxt_s = ST_DONE;
                    end else if (turn_r + TURN_W'(1) == TURN_W'(MAX_TURNS)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_PLAY;
                    end
                end
                ST_DONE:  state_nxt_s = ST_DONE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Game datapath: secret capture, guess scoring and turn bookkeeping.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            secret_r      <= '0;
            guess_r       <= '0;
            exact_pend_r  <= '0;
            hits_r        <= '0;
            color_r       <= '0;
            exact_r       <= '0;
            misplaced_r   <= '0;
            turn_r        <= '0;
            win_r         <= 1'b0;
            lose_r        <= 1'b0;
            score_valid_r <= 1'b0;
        end else if (new_game) begin
            secret_r      <= load_code ? code_in : lfsr_s[CODE_W-1:0];
            hits_r        <= '0;
            color_r       <= '0;
            exact_r       <= '0;
            misplaced_r   <= '0;
            turn_r        <= '0;
            win_r         <= 1'b0;
            lose_r        <= 1'b0;
            score_valid_r <= 1'b0;
        end else begin
            score_valid_r <= 1'b0;
            case (state_r)
                ST_PLAY: begin
                    if (guess_valid) begin
                        guess_r      <= guess;
                        exact_pend_r <= guess_exact_s;
                        hits_r       <= '0;
                        color_r      <= '0;
                    end
                end
                ST_SCORE: begin
                    hits_r  <= hits_nxt_s;
                    color_r <= color_r + COLOR_BITS'(1);
                    if (last_color_s) begin
                        exact_r       <= exact_pend_r;
                        misplaced_r   <= hits_nxt_s - exact_pend_r;
                        score_valid_r <= 1'b1;
                        turn_r        <= turn_r + TURN_W'(1);
                        if (exact_pend_r == CNT_W'(NUM_PEGS)) begin
                            win_r <= 1'b1;
                        end else if (turn_r + TURN_W'(1) == TURN_W'(MAX_TURNS)) begin
                            lose_r <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from registered state.
    always_comb begin
        busy     = (state_r == ST_SCORE);
        code_out = (state_r == ST_DONE) ? secret_r : '0;
    end

    assign score_valid = score_valid_r;
    assign exact       = exact_r;
    assign misplaced   = misplaced_r;
    assign turn_count  = turn_r;
    assign win         = win_r;
    assign lose        = lose_r;

endmodule
